// File: rtl/l2_lru_pkg.sv
// Shared types and default geometry for the L2 LRU arbiter slice.
`timescale 1ns/1ps
package l2_lru_pkg;

  localparam int DEF_NUM_WAYS   = 8;
  localparam int DEF_WAY_BITS   = 3;
  localparam int DEF_INDEX_BITS = 7;
  localparam int DEF_ROW_BITS   = DEF_WAY_BITS * DEF_NUM_WAYS;

  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    IDLE  = 2'd2,
    RMW   = 2'd3
  } state_e;

endpackage

// File: rtl/l2_lru_if.sv
// Request/response ports for both processors plus the LRU RAM port.
`timescale 1ns/1ps
interface l2_lru_if
  import l2_lru_pkg::*;
#(
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int WAY_BITS   = DEF_WAY_BITS,
  parameter int INDEX_BITS = DEF_INDEX_BITS
);
  localparam int ROW_BITS = WAY_BITS * NUM_WAYS;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_hit;
  logic [WAY_BITS-1:0]   req1_way;
  logic [INDEX_BITS-1:0] req1_index;
  logic                  rsp1_valid;
  logic [WAY_BITS-1:0]   rsp1_way;

  logic                  req2_valid;
  logic                  req2_ready;
  logic                  req2_hit;
  logic [WAY_BITS-1:0]   req2_way;
  logic [INDEX_BITS-1:0] req2_index;
  logic                  rsp2_valid;
  logic [WAY_BITS-1:0]   rsp2_way;

  logic                  ram_rd_en;
  logic                  ram_wr_en;
  logic [INDEX_BITS-1:0] ram_addr;
  logic [ROW_BITS-1:0]   ram_wdata;
  logic [ROW_BITS-1:0]   ram_rdata;

  modport slave (
    input  req1_valid, req1_hit, req1_way, req1_index,
    input  req2_valid, req2_hit, req2_way, req2_index,
    input  ram_rdata,
    output req1_ready, rsp1_valid, rsp1_way,
    output req2_ready, rsp2_valid, rsp2_way,
    output ram_rd_en, ram_wr_en, ram_addr, ram_wdata
  );

  modport master (
    output req1_valid, req1_hit, req1_way, req1_index,
    output req2_valid, req2_hit, req2_way, req2_index,
    output ram_rdata,
    input  req1_ready, rsp1_valid, rsp1_way,
    input  req2_ready, rsp2_valid, rsp2_way,
    input  ram_rd_en, ram_wr_en, ram_addr, ram_wdata
  );

endinterface

// File: rtl/l2_lru_age_update.sv
// Combinational age-row update: picks hit way or LRU victim and makes it MRU.
// L2_LRU_PERM_CHECK_EN adds a duplicate-age detector on the incoming row.
`timescale 1ns/1ps
module l2_lru_age_update
  import l2_lru_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int WAY_BITS = DEF_WAY_BITS
) (
  input  logic [WAY_BITS*NUM_WAYS-1:0] i_row,
  input  logic                         i_hit,
  input  logic [WAY_BITS-1:0]          i_way,
  output logic [WAY_BITS*NUM_WAYS-1:0] o_row,
  output logic [WAY_BITS-1:0]          o_way
`ifdef L2_LRU_PERM_CHECK_EN
  ,
  output logic                         o_perm_err
`endif
);
  localparam logic [WAY_BITS-1:0] AGE_MRU = WAY_BITS'(NUM_WAYS - 1);
  localparam logic [WAY_BITS-1:0] AGE_ONE = WAY_BITS'(1);
  localparam logic [WAY_BITS-1:0] AGE_LRU = {WAY_BITS{1'b0}};

  logic [WAY_BITS-1:0] w_victim;
  logic [WAY_BITS-1:0] w_sel;
  logic [WAY_BITS-1:0] w_sel_age;

  // Victim search: ascending scan so the highest-indexed age-0 way wins.
  always_comb begin
    w_victim = AGE_LRU;
    for (int j = 0; j < NUM_WAYS; j++) begin
      if (i_row[j*WAY_BITS +: WAY_BITS] == AGE_LRU) begin
        w_victim = WAY_BITS'(j);
      end else begin
        w_victim = w_victim;
      end
    end
  end

  // Promote the selected way to MRU and close the gap it leaves.
  always_comb begin
    if (i_hit) begin
      w_sel = i_way;
    end else begin
      w_sel = w_victim;
    end
    w_sel_age = i_row[w_sel*WAY_BITS +: WAY_BITS];
    o_row     = {(WAY_BITS*NUM_WAYS){1'b0}};
    for (int j = 0; j < NUM_WAYS; j++) begin
      if (WAY_BITS'(j) == w_sel) begin
        o_row[j*WAY_BITS +: WAY_BITS] = AGE_MRU;
      end else if (i_row[j*WAY_BITS +: WAY_BITS] > w_sel_age) begin
        o_row[j*WAY_BITS +: WAY_BITS] = i_row[j*WAY_BITS +: WAY_BITS] - AGE_ONE;
      end else begin
        o_row[j*WAY_BITS +: WAY_BITS] = i_row[j*WAY_BITS +: WAY_BITS];
      end
    end
    o_way = w_sel;
  end

`ifdef L2_LRU_PERM_CHECK_EN
  logic [NUM_WAYS-1:0] w_seen;

  // Any age seen twice means the stored row is not a permutation.
  always_comb begin
    w_seen     = {NUM_WAYS{1'b0}};
    o_perm_err = 1'b0;
    for (int j = 0; j < NUM_WAYS; j++) begin
      if (w_seen[i_row[j*WAY_BITS +: WAY_BITS]]) begin
        o_perm_err = 1'b1;
      end else begin
        w_seen[i_row[j*WAY_BITS +: WAY_BITS]] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/l2_lru_arbiter.sv
// Two-port round-robin read-modify-write sequencer for the L2 LRU age RAM,
// with a post-reset init sweep. Optional row check: L2_LRU_PERM_CHECK_EN.
`timescale 1ns/1ps
module l2_lru_arbiter
  import l2_lru_pkg::*;
#(
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int WAY_BITS   = DEF_WAY_BITS,
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic    CLK,
  input  logic    RST,
  l2_lru_if.slave io_bus,
  output logic    o_init_busy,
  output logic    o_lru_err
);
  localparam int NUM_SETS = 1 << INDEX_BITS;
  localparam int ROW_BITS = WAY_BITS * NUM_WAYS;
  localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(NUM_SETS - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [INDEX_BITS-1:0] r_init_idx;
  logic [INDEX_BITS-1:0] r_index;
  logic                  r_ptr;
  logic                  r_port;
  logic                  r_hit;
  logic [WAY_BITS-1:0]   r_way;
  logic                  r_init_busy;

  logic                  w_grant;
  logic                  w_pick2;
  logic                  w_req_hit;
  logic [WAY_BITS-1:0]   w_req_way;
  logic [INDEX_BITS-1:0] w_req_index;
  logic [WAY_BITS-1:0]   w_sel_way;
  logic [ROW_BITS-1:0]   w_init_row;
  logic [ROW_BITS-1:0]   w_new_row;

  for (genvar g_j = 0; g_j < NUM_WAYS; g_j++) begin : g_init_row
    assign w_init_row[g_j*WAY_BITS +: WAY_BITS] = WAY_BITS'(g_j);
  end

`ifdef L2_LRU_PERM_CHECK_EN
  logic w_perm_err;
  logic w_err_now;
  logic r_lru_err;
`endif

  l2_lru_age_update #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_age_update (
    .i_row      (io_bus.ram_rdata),
    .i_hit      (r_hit),
    .i_way      (r_way),
    .o_row      (w_new_row),
    .o_way      (w_sel_way)
`ifdef L2_LRU_PERM_CHECK_EN
    ,
    .o_perm_err (w_perm_err)
`endif
  );

  // Arbitration: the pointer only matters when both ports are requesting.
  always_comb begin
    if (io_bus.req2_valid && (!io_bus.req1_valid || r_ptr)) begin
      w_pick2 = 1'b1;
    end else begin
      w_pick2 = 1'b0;
    end
    w_grant = (r_state == IDLE) && (io_bus.req1_valid || io_bus.req2_valid);
    if (w_pick2) begin
      w_req_hit   = io_bus.req2_hit;
      w_req_way   = io_bus.req2_way;
      w_req_index = io_bus.req2_index;
    end else begin
      w_req_hit   = io_bus.req1_hit;
      w_req_way   = io_bus.req1_way;
      w_req_index = io_bus.req1_index;
    end
  end

  // Next-state and RAM/handshake outputs.
  always_comb begin
    w_state_nxt       = r_state;
    io_bus.req1_ready = 1'b0;
    io_bus.req2_ready = 1'b0;
    io_bus.rsp1_valid = 1'b0;
    io_bus.rsp2_valid = 1'b0;
    io_bus.rsp1_way   = {WAY_BITS{1'b0}};
    io_bus.rsp2_way   = {WAY_BITS{1'b0}};
    io_bus.ram_rd_en  = 1'b0;
    io_bus.ram_wr_en  = 1'b0;
    io_bus.ram_addr   = {INDEX_BITS{1'b0}};
    io_bus.ram_wdata  = {ROW_BITS{1'b0}};
    case (r_state)
      START: begin
        w_state_nxt = INIT;
      end
      INIT: begin
        io_bus.ram_wr_en = 1'b1;
        io_bus.ram_addr  = r_init_idx;
        io_bus.ram_wdata = w_init_row;
        if (r_init_idx == LAST_SET) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = INIT;
        end
      end
      IDLE: begin
        if (w_grant) begin
          io_bus.req1_ready = ~w_pick2;
          io_bus.req2_ready = w_pick2;
          io_bus.ram_rd_en  = 1'b1;
          io_bus.ram_addr   = w_req_index;
          w_state_nxt       = RMW;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RMW: begin
        io_bus.ram_wr_en = 1'b1;
        io_bus.ram_addr  = r_index;
        io_bus.ram_wdata = w_new_row;
        if (r_port) begin
          io_bus.rsp2_valid = 1'b1;
          io_bus.rsp2_way   = w_sel_way;
        end else begin
          io_bus.rsp1_valid = 1'b1;
          io_bus.rsp1_way   = w_sel_way;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = START;
      end
    endcase
  end

  // State register; init_busy is held from reset until the sweep's last set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= START;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_init_busy <= (w_state_nxt == START) || (w_state_nxt == INIT);
    end
  end

  // Sweep counter, round-robin pointer and the request latched at grant.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_init_idx <= {INDEX_BITS{1'b0}};
      r_ptr      <= 1'b0;
      r_port     <= 1'b0;
      r_hit      <= 1'b0;
      r_way      <= {WAY_BITS{1'b0}};
      r_index    <= {INDEX_BITS{1'b0}};
    end else begin
      if (r_state == INIT) begin
        r_init_idx <= r_init_idx + 1'b1;
      end else begin
        r_init_idx <= {INDEX_BITS{1'b0}};
      end
      if (w_grant) begin
        r_ptr   <= ~w_pick2;
        r_port  <= w_pick2;
        r_hit   <= w_req_hit;
        r_way   <= w_req_way;
        r_index <= w_req_index;
      end else begin
        r_ptr   <= r_ptr;
        r_port  <= r_port;
        r_hit   <= r_hit;
        r_way   <= r_way;
        r_index <= r_index;
      end
    end
  end

  assign o_init_busy = r_init_busy;

`ifdef L2_LRU_PERM_CHECK_EN
  assign w_err_now = (r_state == RMW) && w_perm_err;

  // Corrupt-row flag is visible in the RMW cycle and sticks until reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lru_err <= 1'b0;
    end else begin
      r_lru_err <= r_lru_err | w_err_now;
    end
  end

  assign o_lru_err = r_lru_err | w_err_now;
`else
  assign o_lru_err = 1'b0;
`endif

endmodule

// File: tb/tb_l2_lru_arbiter.sv
// Randomized bench for l2_lru_arbiter with a recency-list reference model.
`timescale 1ns/1ps
module tb_l2_lru_arbiter;

  localparam logic [23:0] IDENT = 24'o76543210;
`ifdef L2_LRU_PERM_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic init_busy;
  logic lru_err;
  always #5 CLK = ~CLK;

  l2_lru_if bus ();

  l2_lru_arbiter dut (
    .CLK         (CLK),
    .RST         (RST),
    .io_bus      (bus),
    .o_init_busy (init_busy),
    .o_lru_err   (lru_err)
  );

  // Single-port synchronous RAM with an override for corrupt-row injection.
  logic [23:0] mem [128];
  logic [23:0] ram_q;
  bit          corrupt = 1'b0;
  logic [23:0] bad_row = 24'o76543200;
  always @(posedge CLK) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rd_en) ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = corrupt ? bad_row : ram_q;

  int k;
  always @(posedge CLK or negedge RST) begin
    if (!RST) k <= 0;
    else      k <= k + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: per set, ways ordered from LRU (slot 0) to MRU (slot 7).
  int ord [128][8];
  bit m_pend, m_ptr, m_bad, m_err;
  int m_port, m_rway, grant_k, rsp_k, last_port;
  logic [6:0]  m_idx;
  logic [23:0] m_row, last_wdata;
  logic [2:0]  last_way;
  int g_port_q[$];
  int g_time_q[$];

  task automatic model_reset();
    for (int s = 0; s < 128; s++)
      for (int p = 0; p < 8; p++) ord[s][p] = p;
    m_pend = 1'b0;
    m_ptr  = 1'b0;
  endtask

  task automatic touch(input int s, input bit hit, input int way, output int w);
    int pos;
    w   = hit ? way : ord[s][0];
    pos = 0;
    for (int p = 0; p < 8; p++) if (ord[s][p] == w) pos = p;
    for (int p = pos; p < 7; p++) ord[s][p] = ord[s][p+1];
    ord[s][7] = w;
  endtask

  function automatic logic [23:0] enc(input int s);
    logic [23:0] r = 24'd0;
    for (int p = 0; p < 8; p++) r[3*ord[s][p] +: 3] = 3'(p);
    return r;
  endfunction

  // Per-cycle compare of every DUT output against the model.
  always @(negedge CLK) begin : cmp
    int g, w, idx;
    bit h;
    logic [5:0] ctl;
    ctl = {bus.req1_ready, bus.req2_ready, bus.rsp1_valid, bus.rsp2_valid,
           bus.ram_rd_en, bus.ram_wr_en};
    if (!RST || k == 0) begin
      if (!RST) begin
        model_reset();
        m_err = 1'b0;
      end
      check("rst_ctl", 32'(ctl), 32'd0);
      check("rst_addr", 32'(bus.ram_addr), 32'd0);
      check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
      check("rst_rspway", 32'({bus.rsp1_way, bus.rsp2_way}), 32'd0);
      check("rst_busy", 32'(init_busy), 32'd1);
      check("rst_err", 32'(lru_err), 32'd0);
    end else if (k <= 128) begin
      check("init_ctl", 32'(ctl), 32'd1);
      check("init_addr", 32'(bus.ram_addr), 32'(k - 1));
      check("init_wdata", 32'(bus.ram_wdata), 32'(IDENT));
      check("init_busy", 32'(init_busy), 32'd1);
      check("init_err", 32'(lru_err), 32'(m_err));
    end else begin
      check("busy_low", 32'(init_busy), 32'd0);
      if (m_pend) begin
        m_pend = 1'b0;
        rsp_k  = k;
        if (m_bad) m_err = ERR_EN;
        check("rsp_ctl", 32'(ctl), (m_port == 1) ? 32'b001001 : 32'b000101);
        check("wr_addr", 32'(bus.ram_addr), 32'(m_idx));
        last_way = (m_port == 1) ? bus.rsp1_way : bus.rsp2_way;
        if (!m_bad) begin
          check("rsp_way", 32'(last_way), 32'(m_rway));
          check("wr_row", 32'(bus.ram_wdata), 32'(m_row));
        end
        last_wdata = bus.ram_wdata;
        last_port  = m_port;
      end else begin
        if (bus.req1_valid && bus.req2_valid) g = m_ptr ? 2 : 1;
        else if (bus.req1_valid) g = 1;
        else if (bus.req2_valid) g = 2;
        else g = 0;
        check("idle_ctl", 32'(ctl), (g == 1) ? 32'b100010 : (g == 2) ? 32'b010010 : 32'd0);
        if (g != 0) begin
          idx = (g == 1) ? int'(bus.req1_index) : int'(bus.req2_index);
          h   = (g == 1) ? bus.req1_hit : bus.req2_hit;
          w   = (g == 1) ? int'(bus.req1_way) : int'(bus.req2_way);
          check("rd_addr", 32'(bus.ram_addr), 32'(idx));
          touch(idx, h, w, m_rway);
          m_row   = enc(idx);
          m_idx   = 7'(idx);
          m_port  = g;
          m_bad   = corrupt;
          m_pend  = 1'b1;
          m_ptr   = (g == 1);
          grant_k = k;
          g_port_q.push_back(g);
          g_time_q.push_back(k);
        end
      end
      check("err", 32'(lru_err), 32'(m_err));
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      #1;
      ok = (p == 1) ? bus.req1_ready : bus.req2_ready;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic req(input int p, input bit h, input int w, input int ix);
    bit ok;
    if (p == 1) begin
      bus.req1_hit = h; bus.req1_way = 3'(w); bus.req1_index = 7'(ix); bus.req1_valid = 1'b1;
    end else begin
      bus.req2_hit = h; bus.req2_way = 3'(w); bus.req2_index = 7'(ix); bus.req2_valid = 1'b1;
    end
    wait_ready(p, ok);
    sync();
    if (p == 1) bus.req1_valid = 1'b0;
    else        bus.req2_valid = 1'b0;
  endtask

  task automatic burst_same_set(input int p);
    for (int i = 0; i < 4; i++) req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 9);
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) sync();
      req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
    end
  endtask

  initial begin : main
    bit ok;
    int w;
    bus.req1_valid = 1'b0; bus.req1_hit = 1'b0; bus.req1_way = 3'd0; bus.req1_index = 7'd0;
    bus.req2_valid = 1'b0; bus.req2_hit = 1'b0; bus.req2_way = 3'd0; bus.req2_index = 7'd0;

    // Pin the model against hand-computed rows.
    model_reset();
    check("model_ident", 32'(enc(0)), 32'(IDENT));
    touch(5, 1'b1, 3, w);
    check("model_hit5", 32'(enc(5)), 32'(24'o65437210));
    touch(6, 1'b0, 0, w);
    check("model_miss6", 32'(enc(6)), 32'(24'o65432107));
    check("model_victim", 32'(w), 32'd0);
    model_reset();

    // Request pending through reset and the whole sweep.
    bus.req1_hit = 1'b1; bus.req1_way = 3'd3; bus.req1_index = 7'd5; bus.req1_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    wait_ready(1, ok);
    check("first_grant_cycle", 32'(grant_k), 32'd129);
    check("mem0_init", 32'(mem[0]), 32'(IDENT));
    check("mem127_init", 32'(mem[127]), 32'(IDENT));

    // Reset during RMW: request dropped, sweep restarts, request regranted.
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    wait_ready(1, ok);
    check("regrant_cycle", 32'(grant_k), 32'd129);
    sync();
    bus.req1_valid = 1'b0;
    @(negedge CLK);
    #1;
    check("hit5_row", 32'(last_wdata), 32'(24'o65437210));
    check("hit5_way", 32'(last_way), 32'd3);
    check("hit5_port", 32'(last_port), 32'd1);
    check("hit5_rsp_lat", 32'(rsp_k - grant_k), 32'd1);

    // Miss on a fresh set from port 2.
    sync();
    req(2, 1'b0, 0, 6);
    @(negedge CLK);
    #1;
    check("miss6_row", 32'(last_wdata), 32'(24'o65432107));
    check("miss6_way", 32'(last_way), 32'd0);
    check("miss6_port", 32'(last_port), 32'd2);

    // Both ports hammering set 9: strict alternation, 2-cycle spacing.
    sync();
    g_port_q.delete();
    g_time_q.delete();
    fork
      burst_same_set(1);
      burst_same_set(2);
    join
    repeat (2) sync();
    check("alt_count", 32'(g_port_q.size()), 32'd8);
    for (int i = 1; i < g_port_q.size(); i++) begin
      check("alt_port", 32'(g_port_q[i] != g_port_q[i-1]), 32'd1);
      check("alt_gap", 32'(g_time_q[i] - g_time_q[i-1]), 32'd2);
    end

    // Random traffic from both ports over a few sets.
    fork
      rand_port(1, 30);
      rand_port(2, 30);
    join
    repeat (2) sync();

    // Corrupt row: ways 0 and 1 both at age 0; the higher index is the victim.
    corrupt = 1'b1;
    req(1, 1'b0, 0, 100);
    @(negedge CLK);
    #1;
    check("bad_row_written", 32'(last_wdata), 32'(24'o65432170));
    check("bad_victim", 32'(last_way), 32'd1);
    corrupt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sync();
      check("err_sticky", 32'(lru_err), 32'(ERR_EN));
    end

    // Reset clears the flag and reruns the sweep.
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    repeat (135) sync();
    check("err_after_rst", 32'(lru_err), 32'd0);
    check("busy_after_sweep", 32'(init_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
